// File: rtl/spi_flash_arbiter_pkg.sv
// rtl/spi_flash_arbiter_pkg.sv - shared constants and types for the SPI flash arbiter
package spi_flash_arbiter_pkg;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int CMD_BITS     = 8;
    localparam int ADDR_BITS    = 24;
    localparam int IF_DATA_BITS = 16;
    localparam int DR_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_CMD   = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DATA  = 3'd4,
        ST_DONE  = 3'd5,
        ST_GAP   = 3'd6
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DR = 1'b1
    } port_e;

    // 24-bit flash address add; any carry out of bit 23 is dropped so the
    // address space wraps back to zero.
    function automatic logic [23:0] add24(input logic [23:0] a, input logic [23:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/spi_flash_arbiter_shift_engine.sv
// rtl/spi_flash_arbiter_shift_engine.sv - SCLK divider, TX/RX shifters and bit counter
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         load tx_data and clear divider/bit counter (while not running)
//   tx_data      32-bit command+address word, shifted out MSB first
//   run          advance the bit clock
//   last_bit     index of the final bit of the transaction
//   miso         serial input, sampled on the clk edge where sclk rises
//   sclk, mosi   serial clock and data out
//   bit_end      strobe in the last clk cycle of each bit
//   done         bit_end of the final bit
//   bit_idx      index of the bit currently on the wire
//   rx_data      last 16 bits received, newest in bit 0
module spi_shift_engine #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] tx_data,
    input  logic        run,
    input  logic [5:0]  last_bit,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        bit_end,
    output logic        done,
    output logic [5:0]  bit_idx,
    output logic [15:0] rx_data
);

    logic [3:0]  div_q,  div_d;
    logic        sclk_q, sclk_d;
    logic [5:0]  bit_q,  bit_d;
    logic [31:0] tx_q,   tx_d;
    logic [15:0] rx_q,   rx_d;
    logic        half_end;

    assign half_end = run && (div_q == 4'(CLK_DIV - 1));
    assign bit_end  = half_end && sclk_q;
    assign done     = bit_end && (bit_q == last_bit);

    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        bit_d  = bit_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        if (load) begin
            div_d  = 4'd0;
            sclk_d = 1'b0;
            bit_d  = 6'd0;
            tx_d   = tx_data;
        end else if (run) begin
            if (half_end) begin
                div_d  = 4'd0;
                sclk_d = ~sclk_q;
                if (!sclk_q) begin
                    rx_d = {rx_q[14:0], miso};
                end else begin
                    // Falling edge: next MOSI bit goes out while sclk is low.
                    tx_d  = {tx_q[30:0], 1'b0};
                    bit_d = bit_q + 6'd1;
                end
            end else begin
                div_d = div_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= 4'd0;
            sclk_q <= 1'b0;
            bit_q  <= 6'd0;
            tx_q   <= 32'd0;
            rx_q   <= 16'd0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
            bit_q  <= bit_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = tx_q[31];
    assign bit_idx = bit_q;
    assign rx_data = rx_q;

endmodule

// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - shares one SPI flash READ link between fetch and data ports
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ena                        allow new grants
//   if_req/if_addr             fetch request, 16-bit word address
//   if_rdata/if_valid          fetched word and its one-cycle strobe
//   dr_req/dr_addr             data read request, 16-bit byte address
//   dr_rdata/dr_valid          read byte and its one-cycle strobe
//   busy                       grant through end of inter-transaction gap
//   spi_cs/spi_sclk            chip select (active low), mode-0 clock
//   spi_io0_o/spi_io0_oe       MOSI and its drive enable
//   spi_io1_i                  MISO
module spi_flash_arbiter
    import spi_flash_arbiter_pkg::*;
#(
    parameter int          CLK_DIV   = 2,
    parameter logic [23:0] IMEM_BASE = 24'h000000,
    parameter logic [23:0] DMEM_BASE = 24'h010000,
    parameter int          GAP_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_valid,
    input  logic        dr_req,
    input  logic [15:0] dr_addr,
    output logic [7:0]  dr_rdata,
    output logic        dr_valid,
    output logic        busy,
    output logic        spi_cs,
    output logic        spi_sclk,
    output logic        spi_io0_o,
    output logic        spi_io0_oe,
    input  logic        spi_io1_i
);

    state_e      state_q,    state_d;
    port_e       port_q,     port_d;
    port_e       last_q,     last_d;
    logic [7:0]  gap_q,      gap_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [7:0]  dr_rdata_q, dr_rdata_d;
    logic        if_valid_q, if_valid_d;
    logic        dr_valid_q, dr_valid_d;

    logic        eng_load;
    logic [31:0] eng_tx;
    logic        eng_run;
    logic [5:0]  eng_last_bit;
    logic        eng_mosi;
    logic        eng_bit_end;
    logic        eng_done;
    logic [5:0]  eng_bit_idx;
    logic [15:0] eng_rx;

    logic [23:0] if_flash_addr;
    logic [23:0] dr_flash_addr;
    logic        grant_if;

    assign if_flash_addr = add24(IMEM_BASE, {7'd0, if_addr, 1'b0});
    assign dr_flash_addr = add24(DMEM_BASE, {8'd0, dr_addr});

    // Round-robin tie break: fetch wins unless it was the last port served.
    assign grant_if = if_req && (!dr_req || (last_q == PORT_DR));

    assign eng_run      = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign eng_last_bit = (port_q == PORT_IF) ? 6'(CMD_BITS + ADDR_BITS + IF_DATA_BITS - 1)
                                              : 6'(CMD_BITS + ADDR_BITS + DR_DATA_BITS - 1);

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        last_d     = last_q;
        gap_d      = gap_q;
        if_rdata_d = if_rdata_q;
        dr_rdata_d = dr_rdata_q;
        if_valid_d = 1'b0;
        dr_valid_d = 1'b0;
        eng_load   = 1'b0;
        eng_tx     = {SPI_CMD_READ, if_flash_addr};
        case (state_q)
            ST_IDLE: begin
                if (ena && (if_req || dr_req)) begin
                    // Address and port are captured here; the engine holds the
                    // whole command word so later input changes are ignored.
                    eng_load = 1'b1;
                    state_d  = ST_SETUP;
                    if (grant_if) begin
                        port_d = PORT_IF;
                        last_d = PORT_IF;
                        eng_tx = {SPI_CMD_READ, if_flash_addr};
                    end else begin
                        port_d = PORT_DR;
                        last_d = PORT_DR;
                        eng_tx = {SPI_CMD_READ, dr_flash_addr};
                    end
                end
            end
            ST_SETUP: state_d = ST_CMD;
            ST_CMD: begin
                if (eng_bit_end && (eng_bit_idx == 6'(CMD_BITS - 1))) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (eng_bit_end && (eng_bit_idx == 6'(CMD_BITS + ADDR_BITS - 1))) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (eng_done) begin
                    state_d = ST_DONE;
                    if (port_q == PORT_IF) begin
                        if_rdata_d = eng_rx;
                        if_valid_d = 1'b1;
                    end else begin
                        dr_rdata_d = eng_rx[7:0];
                        dr_valid_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_GAP;
                gap_d   = 8'd0;
            end
            ST_GAP: begin
                if (gap_q == 8'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            port_q     <= PORT_IF;
            last_q     <= PORT_DR;
            gap_q      <= 8'd0;
            if_rdata_q <= 16'd0;
            dr_rdata_q <= 8'd0;
            if_valid_q <= 1'b0;
            dr_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            last_q     <= last_d;
            gap_q      <= gap_d;
            if_rdata_q <= if_rdata_d;
            dr_rdata_q <= dr_rdata_d;
            if_valid_q <= if_valid_d;
            dr_valid_q <= dr_valid_d;
        end
    end

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (eng_load),
        .tx_data  (eng_tx),
        .run      (eng_run),
        .last_bit (eng_last_bit),
        .miso     (spi_io1_i),
        .sclk     (spi_sclk),
        .mosi     (eng_mosi),
        .bit_end  (eng_bit_end),
        .done     (eng_done),
        .bit_idx  (eng_bit_idx),
        .rx_data  (eng_rx)
    );

    assign spi_cs     = !((state_q == ST_SETUP) || eng_run);
    assign spi_io0_oe = (state_q == ST_SETUP) || (state_q == ST_CMD) || (state_q == ST_ADDR);
    assign spi_io0_o  = spi_io0_oe && eng_mosi;
    assign busy       = (state_q != ST_IDLE);
    assign if_rdata   = if_rdata_q;
    assign dr_rdata   = dr_rdata_q;
    assign if_valid   = if_valid_q;
    assign dr_valid   = dr_valid_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - directed self-checking bench for spi_flash_arbiter
`timescale 1ns/1ps
module tb_spi_flash_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Instance a: default parameters. Instance b: CLK_DIV=1, DMEM_BASE=24'hFFFFF0.
    logic        ena_a, if_req_a, dr_req_a, if_valid_a, dr_valid_a, busy_a;
    logic [15:0] if_addr_a, dr_addr_a, if_rdata_a;
    logic [7:0]  dr_rdata_a;
    logic        cs_a, sclk_a, mosi_a, oe_a;
    logic        miso_a = 1'b0;
    logic        ena_b, if_req_b, dr_req_b, if_valid_b, dr_valid_b, busy_b;
    logic [15:0] if_addr_b, dr_addr_b, if_rdata_b;
    logic [7:0]  dr_rdata_b;
    logic        cs_b, sclk_b, mosi_b, oe_b;
    logic        miso_b = 1'b0;

    spi_flash_arbiter u_dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena_a),
        .if_req(if_req_a), .if_addr(if_addr_a), .if_rdata(if_rdata_a), .if_valid(if_valid_a),
        .dr_req(dr_req_a), .dr_addr(dr_addr_a), .dr_rdata(dr_rdata_a), .dr_valid(dr_valid_a),
        .busy(busy_a), .spi_cs(cs_a), .spi_sclk(sclk_a), .spi_io0_o(mosi_a),
        .spi_io0_oe(oe_a), .spi_io1_i(miso_a)
    );

    spi_flash_arbiter #(.CLK_DIV(1), .DMEM_BASE(24'hFFFFF0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena_b),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b), .if_valid(if_valid_b),
        .dr_req(dr_req_b), .dr_addr(dr_addr_b), .dr_rdata(dr_rdata_b), .dr_valid(dr_valid_b),
        .busy(busy_b), .spi_cs(cs_b), .spi_sclk(sclk_b), .spi_io0_o(mosi_b),
        .spi_io0_oe(oe_b), .spi_io1_i(miso_b)
    );

    // Flash models: capture 32 command/address bits on rising SCLK, then
    // present fl_word MSB first, changing on falling SCLK.
    logic [15:0] fl_word = 16'h0000;
    int          cnt_a = 0, cnt_b = 0;
    logic [31:0] ca_a = 32'd0, ca_b = 32'd0;
    logic        sp_a = 1'b0, sp_b = 1'b0;

    always @(cs_a or sclk_a) begin
        if (cs_a) cnt_a = 0;
        else if (sclk_a && !sp_a) begin
            if (cnt_a < 32) ca_a = {ca_a[30:0], mosi_a};
            cnt_a++;
        end else if (!sclk_a && sp_a && cnt_a >= 32 && cnt_a < 48) miso_a = fl_word[4'(47 - cnt_a)];
        sp_a = sclk_a;
    end

    always @(cs_b or sclk_b) begin
        if (cs_b) cnt_b = 0;
        else if (sclk_b && !sp_b) begin
            if (cnt_b < 32) ca_b = {ca_b[30:0], mosi_b};
            cnt_b++;
        end else if (!sclk_b && sp_b && cnt_b >= 32 && cnt_b < 48) miso_b = fl_word[4'(47 - cnt_b)];
        sp_b = sclk_b;
    end

    int          sel = 0;
    logic        m_busy, m_if_valid, m_dr_valid, m_cs, m_oe;
    logic [15:0] m_if_rdata;
    logic [7:0]  m_dr_rdata;
    logic [31:0] m_ca;

    always_comb begin
        m_busy = busy_a; m_if_valid = if_valid_a; m_dr_valid = dr_valid_a; m_cs = cs_a;
        m_oe = oe_a; m_if_rdata = if_rdata_a; m_dr_rdata = dr_rdata_a; m_ca = ca_a;
        if (sel != 0) begin
            m_busy = busy_b; m_if_valid = if_valid_b; m_dr_valid = dr_valid_b; m_cs = cs_b;
            m_oe = oe_b; m_if_rdata = if_rdata_b; m_dr_rdata = dr_rdata_b; m_ca = ca_b;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic ir, input logic dr, input logic [15:0] addr);
        if (s == 0) begin if_req_a = ir; dr_req_a = dr; if_addr_a = addr; dr_addr_a = addr; end
        else        begin if_req_b = ir; dr_req_b = dr; if_addr_b = addr; dr_addr_b = addr; end
    endtask

    // One single-requester read. lat counts the SETUP cycle as 1.
    task automatic run_txn(input int s, input logic is_if, input logic [15:0] addr,
                           input logic [15:0] word, output int lat,
                           output logic [15:0] got, output logic [31:0] ca);
        int n;
        sel = s;
        fl_word = word;
        @(negedge clk);
        drive(s, is_if, !is_if, addr);
        n = 0;
        while (!m_busy && n < 20) begin @(negedge clk); n++; end
        check("setup_link", {m_cs, m_oe}, 2'b01);
        lat = 1;
        while (!(m_if_valid || m_dr_valid) && lat < 400) begin @(negedge clk); lat++; end
        got = is_if ? m_if_rdata : {8'h00, m_dr_rdata};
        ca  = m_ca;
        check("valid_port", {m_if_valid, m_dr_valid}, is_if ? 2'b10 : 2'b01);
        check("done_link", {m_cs, m_oe}, 2'b10);
        drive(s, 1'b0, 1'b0, addr);
        @(negedge clk);
        check("valid_once", {m_if_valid, m_dr_valid}, 2'b00);
        n = 0;
        while (m_busy && n < 50) begin @(negedge clk); n++; end
    endtask

    typedef struct {
        logic        is_if;
        logic [15:0] addr;
        logic [15:0] word;
        logic [31:0] exp_ca;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          lat, n, hi;
        logic [15:0] got, exp_if_hold;
        logic [31:0] ca;
        logic [7:0]  exp_dr_hold;
        logic        seen_if;

        vecs[0] = '{1'b1, 16'h0005, 16'hA55A, 32'h0300000A, 16'hA55A, 194};
        vecs[1] = '{1'b0, 16'h0010, 16'h3C00, 32'h03010010, 16'h003C, 162};
        vecs[2] = '{1'b1, 16'hFFFF, 16'h1234, 32'h0301FFFE, 16'h1234, 194};
        vecs[3] = '{1'b0, 16'hFFFF, 16'hC300, 32'h0301FFFF, 16'h00C3, 162};
        vecs[4] = '{1'b1, 16'h8000, 16'hFFFF, 32'h03010000, 16'hFFFF, 194};
        vecs[5] = '{1'b0, 16'h0000, 16'h8100, 32'h03010000, 16'h0081, 162};

        rst_n = 1'b0;
        ena_a = 1'b1; ena_b = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0000);
        drive(1, 1'b0, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        check("rst_spi", {cs_a, sclk_a, mosi_a, oe_a}, 4'b1000);
        check("rst_rdata", {if_rdata_a, dr_rdata_a}, 24'h0);
        check("rst_flags", {if_valid_a, dr_valid_a, busy_a}, 3'b000);
        rst_n = 1'b1;

        exp_if_hold = 16'h0000;
        exp_dr_hold = 8'h00;
        for (int i = 0; i < 6; i++) begin
            run_txn(0, vecs[i].is_if, vecs[i].addr, vecs[i].word, lat, got, ca);
            check($sformatf("v%0d_wire", i), ca, vecs[i].exp_ca);
            check($sformatf("v%0d_data", i), {16'h0, got}, {16'h0, vecs[i].exp_data});
            check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            if (vecs[i].is_if) exp_if_hold = vecs[i].exp_data;
            else               exp_dr_hold = vecs[i].exp_data[7:0];
            check($sformatf("v%0d_if_hold", i), {16'h0, if_rdata_a}, {16'h0, exp_if_hold});
            check($sformatf("v%0d_dr_hold", i), {24'h0, dr_rdata_a}, {24'h0, exp_dr_hold});
        end

        // Both ports held from reset: fetch, data, fetch, data with a CS-high gap.
        sel = 0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        drive(0, 1'b1, 1'b1, 16'h0002);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(if_valid_a || dr_valid_a) && n < 400) begin @(negedge clk); n++; end
            seen_if = if_valid_a;
            check($sformatf("rr_order%0d", k), {seen_if, dr_valid_a}, (k % 2 == 0) ? 2'b10 : 2'b01);
            hi = 0;
            while (cs_a && hi < 50) begin hi++; @(negedge clk); end
            if (k < 3) check($sformatf("rr_gap%0d", k), (hi >= 2), 1'b1);
        end
        drive(0, 1'b0, 1'b0, 16'h0000);
        n = 0;
        while (busy_a && n < 400) begin @(negedge clk); n++; end

        // Reset at cycle 60 of a fetch aborts the link immediately.
        fl_word = 16'hA55A;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'h0005);
        n = 0;
        while (!busy_a && n < 20) begin @(negedge clk); n++; end
        lat = 1;
        while (lat < 60) begin @(negedge clk); lat++; end
        check("pre_reset_cs", cs_a, 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_cs", {cs_a, busy_a, if_valid_a}, 3'b100);
        drive(0, 1'b0, 1'b0, 16'h0005);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(0, 1'b1, 16'h0005, 16'hA55A, lat, got, ca);
        check("restart_wire", ca, 32'h0300000A);
        check("restart_data", {16'h0, got}, 32'h0000A55A);
        check("restart_lat", lat, 194);

        // ena low blocks grants; dropping ena mid-read lets it complete.
        ena_a = 1'b0;
        drive(0, 1'b1, 1'b0, 16'h0007);
        n = 0;
        for (int c = 0; c < 20; c++) begin @(negedge clk); if (!cs_a || busy_a) n++; end
        check("ena0_idle", n, 0);
        drive(0, 1'b0, 1'b1, 16'h0042);
        fl_word = 16'h5A00;
        ena_a = 1'b1;
        n = 0;
        while (!busy_a && n < 20) begin @(negedge clk); n++; end
        lat = 1;
        while (lat < 10) begin @(negedge clk); lat++; end
        ena_a = 1'b0;
        if_req_a = 1'b1;
        while (!(if_valid_a || dr_valid_a) && lat < 400) begin @(negedge clk); lat++; end
        check("ena_drop_valid", {if_valid_a, dr_valid_a}, 2'b01);
        check("ena_drop_data", dr_rdata_a, 8'h5A);
        check("ena_drop_lat", lat, 162);
        dr_req_a = 1'b0;
        n = 0;
        for (int c = 0; c < 30; c++) begin @(negedge clk); if (!cs_a) n++; end
        check("ena_drop_idle", {n[7:0], busy_a}, 9'd0);
        ena_a = 1'b1;
        @(negedge clk); @(negedge clk);
        check("ena_regrant", busy_a, 1'b1);
        n = 0;
        while (!if_valid_a && n < 400) begin @(negedge clk); n++; end
        drive(0, 1'b0, 1'b0, 16'h0000);
        n = 0;
        while (busy_a && n < 50) begin @(negedge clk); n++; end

        // Instance b: CLK_DIV=1 latency and 24-bit address wrap.
        run_txn(1, 1'b1, 16'h0005, 16'hA55A, lat, got, ca);
        check("b_if_wire", ca, 32'h0300000A);
        check("b_if_data", {16'h0, got}, 32'h0000A55A);
        check("b_if_lat", lat, 98);
        run_txn(1, 1'b0, 16'hFFFF, 16'h9600, lat, got, ca);
        check("b_wrap1_wire", ca, 32'h0300FFEF);
        check("b_wrap1_data", {16'h0, got}, 32'h00000096);
        check("b_dr_lat", lat, 82);
        run_txn(1, 1'b0, 16'h001F, 16'h7E00, lat, got, ca);
        check("b_wrap2_wire", ca, 32'h0300000F);
        check("b_wrap2_data", {16'h0, got}, 32'h0000007E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
